// File: rtl/gobou_layer_seq.sv
// ---------------------------------------------------------------------------
// gobou_layer_seq
//
// Initiator side of the gobou core req/ack handshake. The host fills a small
// table with per-layer fully-connected parameters. A start pulse then runs
// layers 0..count-1 in order. For each layer the sequencer:
//   1. loads the table entry onto the parameter outputs,
//   2. waits for the core to be idle (ack high),
//   3. raises req and holds it until the core drops ack, and
//   4. waits for ack to return high, which marks the layer as finished.
// If ack never falls after req rises, the run is aborted with a sticky err.
//
// Ports
//   clk, xrst        clock; synchronous active-low reset
//   cfg_*            table write port (cfg_we strobe, cfg_addr index, fields)
//   num_layers       layer count, sampled on an accepted start
//   start            run request, single-cycle pulse
//   ack              core status; high means the core is idle
//   req              core request; the core acts on its rising edge
//   in_offset ..     parameters of the current layer, registered
//   relu_en
//   layer_idx        index of the layer being run
//   busy             high from start accept until the end of the run
//   done             single-cycle pulse at the end of a run
//   err              sticky handshake timeout flag
// ---------------------------------------------------------------------------
module gobou_layer_seq #(
  parameter int MAXLAYER      = 8,
  parameter int TIMEOUT       = 2**20,
  parameter int MEMSIZE       = 16,
  parameter int GOBOU_NETSIZE = 16,
  parameter int LWIDTH        = 12
) (
  input  logic                          clk,
  input  logic                          xrst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAXLAYER)-1:0]   cfg_addr,
  input  logic [MEMSIZE-1:0]            cfg_in_off,
  input  logic [MEMSIZE-1:0]            cfg_out_off,
  input  logic [GOBOU_NETSIZE-1:0]      cfg_net_off,
  input  logic [LWIDTH-1:0]             cfg_tot_out,
  input  logic [LWIDTH-1:0]             cfg_tot_in,
  input  logic                          cfg_bias_en,
  input  logic                          cfg_relu_en,
  input  logic [$clog2(MAXLAYER):0]     num_layers,
  input  logic                          start,
  input  logic                          ack,
  output logic                          req,
  output logic [MEMSIZE-1:0]            in_offset,
  output logic [MEMSIZE-1:0]            out_offset,
  output logic [GOBOU_NETSIZE-1:0]      net_offset,
  output logic [LWIDTH-1:0]             total_out,
  output logic [LWIDTH-1:0]             total_in,
  output logic                          bias_en,
  output logic                          relu_en,
  output logic [$clog2(MAXLAYER)-1:0]   layer_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int AW = $clog2(MAXLAYER);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [MEMSIZE-1:0]       in_off;
    logic [MEMSIZE-1:0]       out_off;
    logic [GOBOU_NETSIZE-1:0] net_off;
    logic [LWIDTH-1:0]        tot_out;
    logic [LWIDTH-1:0]        tot_in;
    logic                     bias_en;
    logic                     relu_en;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_REQ,
    S_WAIT
  } state_t;

  // Parameter table; read only in S_LOAD, so the parameter register doubles
  // as the registered read port of the memory.
  entry_t table_mem [MAXLAYER];

  state_t          state_reg;
  entry_t          cur_reg;
  logic [AW-1:0]   layer_idx_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [TW-1:0]   tmo_reg;
  logic            req_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic            addr_ok;
  logic            last_layer;
  entry_t          wr_entry;

  assign wr_entry = '{
    in_off:  cfg_in_off,
    out_off: cfg_out_off,
    net_off: cfg_net_off,
    tot_out: cfg_tot_out,
    tot_in:  cfg_tot_in,
    bias_en: cfg_bias_en,
    relu_en: cfg_relu_en
  };

  // Only matters when MAXLAYER is not a power of two.
  assign addr_ok = (int'(cfg_addr) < MAXLAYER);

  // Requested layer count, clamped to the table depth.
  assign count_next = (num_layers > CW'(MAXLAYER)) ? CW'(MAXLAYER) : num_layers;

  assign last_layer = (({1'b0, layer_idx_reg} + CW'(1)) == count_reg);

  // Table write port. The host cannot alter entries while a run is active,
  // so a layer always uses the value present at start time.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_reg && addr_ok) begin
      table_mem[cfg_addr] <= wr_entry;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_reg     <= S_IDLE;
      cur_reg       <= '0;
      layer_idx_reg <= '0;
      count_reg     <= '0;
      tmo_reg       <= '0;
      req_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (num_layers == '0) begin
              // Empty run: report completion without touching the core.
              done_reg <= 1'b1;
            end else begin
              count_reg     <= count_next;
              err_reg       <= 1'b0;
              layer_idx_reg <= '0;
              busy_reg      <= 1'b1;
              state_reg     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          cur_reg   <= table_mem[layer_idx_reg];
          state_reg <= S_ARM;
        end

        S_ARM: begin
          // Parameters have been stable for at least one cycle here, and
          // req is known low, so the next rise is a clean edge.
          if (ack) begin
            req_reg   <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= S_REQ;
          end
        end

        S_REQ: begin
          if (!ack) begin
            req_reg   <= 1'b0;
            state_reg <= S_WAIT;
          end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle with req high and no response.
            err_reg   <= 1'b1;
            req_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else if (tmo_reg != {TW{1'b1}}) begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end

        S_WAIT: begin
          if (ack) begin
            if (last_layer) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              layer_idx_reg <= layer_idx_reg + AW'(1);
              state_reg     <= S_LOAD;
            end
          end
        end

        default: begin
          req_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req        = req_reg;
  assign in_offset  = cur_reg.in_off;
  assign out_offset = cur_reg.out_off;
  assign net_offset = cur_reg.net_off;
  assign total_out  = cur_reg.tot_out;
  assign total_in   = cur_reg.tot_in;
  assign bias_en    = cur_reg.bias_en;
  assign relu_en    = cur_reg.relu_en;
  assign layer_idx  = layer_idx_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule
